// File: rtl/half_adder_reg_if.sv
// Operand/result bundle for the registered lane-parallel half adder.
// The master drives operands and clear; the slave returns registered results.
interface half_adder_reg_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] HA_in1;
    logic [WIDTH-1:0] HA_in2;
    logic             HA_valid_in;
    logic             HA_clear;
    logic [WIDTH-1:0] HA_sum;
    logic [WIDTH-1:0] HA_cout;
    logic             HA_valid_out;
    logic             HA_carry_seen;
    logic [CNT_W-1:0] HA_carry_cnt;

    modport master (
        output HA_in1,
        output HA_in2,
        output HA_valid_in,
        output HA_clear,
        input  HA_sum,
        input  HA_cout,
        input  HA_valid_out,
        input  HA_carry_seen,
        input  HA_carry_cnt
    );

    modport slave (
        input  HA_in1,
        input  HA_in2,
        input  HA_valid_in,
        input  HA_clear,
        output HA_sum,
        output HA_cout,
        output HA_valid_out,
        output HA_carry_seen,
        output HA_carry_cnt
    );
endinterface

// File: rtl/half_adder_reg.sv
// Registered lane-parallel half adder with sticky carry flag
// and saturating carry-event counter.
module half_adder_reg #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    half_adder_reg_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_c;
    logic             w_event;

    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_cout;
    logic             r_valid;
    logic             r_seen;
    logic [CNT_W-1:0] r_cnt;

    // Lanes are independent: no carry ripples between bits.
    assign w_s     = bus.HA_in1 ^ bus.HA_in2;
    assign w_c     = bus.HA_in1 & bus.HA_in2;
    assign w_event = bus.HA_valid_in & (|w_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= '0;
            r_valid <= 1'b0;
            r_seen  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_valid <= bus.HA_valid_in;
            if (bus.HA_valid_in) begin
                r_sum  <= w_s;
                r_cout <= w_c;
            end
            // Clear wins over a coincident carry event.
            if (bus.HA_clear) begin
                r_seen <= 1'b0;
                r_cnt  <= '0;
            end else if (w_event) begin
                r_seen <= 1'b1;
                if (r_cnt != CNT_MAX)
                    r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.HA_sum        = r_sum;
    assign bus.HA_cout       = r_cout;
    assign bus.HA_valid_out  = r_valid;
    assign bus.HA_carry_seen = r_seen;
    assign bus.HA_carry_cnt  = r_cnt;
endmodule

// File: tb/tb_half_adder_reg.sv
// Directed and random checks of half_adder_reg against a
// lane-arithmetic reference model (WIDTH=8, CNT_W=2).
module tb_half_adder_reg;
    localparam int W  = 8;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    int e_sum, e_cout, e_valid, e_seen, e_cnt;

    half_adder_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    half_adder_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".sum"},   int'(bus.HA_sum),        e_sum);
        chk({tag, ".cout"},  int'(bus.HA_cout),       e_cout);
        chk({tag, ".vout"},  int'(bus.HA_valid_out),  e_valid);
        chk({tag, ".seen"},  int'(bus.HA_carry_seen), e_seen);
        chk({tag, ".cnt"},   int'(bus.HA_carry_cnt),  e_cnt);
    endtask

    task automatic model_reset();
        e_sum = 0; e_cout = 0; e_valid = 0; e_seen = 0; e_cnt = 0;
    endtask

    // Reference: each lane adds two bits; sum is the low bit, carry the high.
    task automatic model_step(input int a, input int b, input int v, input int clr);
        int s, c, t;
        s = 0; c = 0;
        for (int i = 0; i < W; i++) begin
            t = ((a >> i) & 1) + ((b >> i) & 1);
            s += (t % 2) << i;
            c += (t / 2) << i;
        end
        if (v != 0) begin
            e_sum = s;
            e_cout = c;
        end
        e_valid = v;
        if (clr != 0) begin
            e_seen = 0;
            e_cnt = 0;
        end else if (v != 0 && c != 0) begin
            e_seen = 1;
            e_cnt = (e_cnt + 1 > CMAX) ? CMAX : e_cnt + 1;
        end
    endtask

    task automatic step(input string tag, input int a, input int b,
                        input int v, input int clr);
        bus.HA_in1      = W'(a);
        bus.HA_in2      = W'(b);
        bus.HA_valid_in = v[0];
        bus.HA_clear    = clr[0];
        @(posedge clk);
        #1;
        model_step(a, b, v, clr);
        chk_all(tag);
    endtask

    initial begin
        int a, b, v, clr;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.HA_in1 = '0;
        bus.HA_in2 = '0;
        bus.HA_valid_in = 1'b0;
        bus.HA_clear = 1'b0;
        model_reset();
        #12;
        chk_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single-lane truth table, back-to-back
        step("tt00", 0, 0, 1, 0);
        step("tt01", 0, 1, 1, 0);
        step("tt10", 1, 0, 1, 0);
        step("tt11", 1, 1, 1, 0);

        // No inter-lane carry: F0 + 3C -> sum CC, cout 30
        step("f0_3c", 8'hF0, 8'h3C, 1, 0);
        chk("f0_3c.lit_sum", int'(bus.HA_sum), 8'hCC);
        chk("f0_3c.lit_cout", int'(bus.HA_cout), 8'h30);

        // Hold during idle
        step("idle1", 8'hFF, 8'hFF, 0, 0);
        step("idle2", 8'h00, 8'h01, 0, 0);
        step("idle3", 8'h55, 8'hAA, 0, 0);

        // Saturation at 3
        step("clr", 0, 0, 0, 1);
        for (int k = 0; k < 5; k++)
            step("sat", 8'h01, 8'h01, 1, 0);
        chk("sat.lit_cnt", int'(bus.HA_carry_cnt), 3);

        // Clear beats coincident carry; cout still captured
        step("clr_carry", 8'h01, 8'h01, 1, 1);
        chk("clr_carry.lit_cout", int'(bus.HA_cout), 1);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            clr = ($urandom_range(0, 15) == 0) ? 1 : 0;
            step("rand", a, b, v, clr);
        end

        // Async reset between edges with nonzero outputs
        step("pre_rst", 8'hFF, 8'hFF, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 8'h01, 8'h01, 1, 0);
        chk("post_rst.lit_cout", int'(bus.HA_cout), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
